// File: rtl/spc_ctl.sv
// SPC return-stack controller: request capture, strobe timing, depth/err tracking.
// Optional SPC_GUARD_EN suppresses SPC access on overflowing push / underflowing pop.
module spc_ctl #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        state_alu,
  input  logic        state_write,
  input  logic        state_fetch,
  input  logic        req_push,
  input  logic        req_pop,
  input  logic        src_m,
  input  logic [13:0] ret_pc,
  input  logic [18:0] mdata,
  input  logic [18:0] spco,
  input  logic        clear_err,
  output logic [18:0] spcw,
  output logic        spcnt,
  output logic        spush,
  output logic        srp,
  output logic        swp,
  output logic [18:0] spcl,
  output logic [5:0]  depth,
  output logic        ovf,
  output logic        unf
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;
  localparam logic [5:0] FULL     = 6'(DEPTH);

  logic [1:0] state;
  logic       op_push;
  logic       blocked;
  logic       active;
  logic       accept;
  logic       fetch_done;
  logic       set_ovf;
  logic       set_unf;

  always_comb begin
`ifdef SPC_GUARD_EN
    blocked = op_push ? (depth == FULL) : (depth == 6'd0);
`else
    blocked = 1'b0;
`endif
  end

  assign active     = ((state == S_ARMED) || (state == S_ACCESS)) && !blocked;
  assign spcnt      = active;
  assign spush      = active && op_push;
  assign swp        = (state == S_ARMED) && state_write && op_push && !blocked;
  assign srp        = (state == S_ARMED) && state_write && !op_push && !blocked;
  // UPDATE overlaps the next machine cycle's ALU slot, so it accepts too
  assign accept     = state_alu && (req_push || req_pop) &&
                      ((state == S_IDLE) || (state == S_UPDATE));
  assign fetch_done = (state == S_ACCESS) && state_fetch;
  assign set_ovf    = fetch_done && op_push && (depth == FULL);
  assign set_unf    = fetch_done && !op_push && (depth == 6'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      op_push <= 1'b0;
      spcw    <= '0;
      spcl    <= '0;
      depth   <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_UPDATE: begin
          if (accept) begin
            state   <= S_ARMED;
            op_push <= req_push;
            spcw    <= src_m ? mdata : {5'b0, ret_pc};
          end else begin
            state <= S_IDLE;
          end
        end
        S_ARMED: begin
          if (state_fetch)      state <= S_IDLE;
          else if (state_write) state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (state_fetch) state <= S_UPDATE;
        end
        default: state <= S_IDLE;
      endcase

      if (fetch_done) begin
        if (op_push) begin
          if (depth != FULL) depth <= depth + 6'd1;
        end else begin
          if (depth != 6'd0) depth <= depth - 6'd1;
          if (!blocked) spcl <= spco;
        end
      end

      ovf <= (ovf && !clear_err) || set_ovf;
      unf <= (unf && !clear_err) || set_unf;
    end
  end

endmodule

// File: tb/tb_spc_ctl.sv
// Directed bench for spc_ctl: push/pop timing, depth saturation, flags, reset, abort.
// Guard-dependent expectations follow SPC_GUARD_EN.
module tb_spc_ctl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        state_alu, state_write, state_fetch;
  logic        req_push, req_pop, src_m, clear_err;
  logic [13:0] ret_pc;
  logic [18:0] mdata, spco;
  logic [18:0] spcw, spcl;
  logic        spcnt, spush, srp, swp, ovf, unf;
  logic [5:0]  depth;

  int total = 0;
  int fails = 0;

  logic o_swp, o_srp, o_cnt, o_push, o_cntf;
  logic [18:0] o_w;
  logic [18:0] spcl_prev;

`ifdef SPC_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  spc_ctl dut (
    .clk(clk), .reset_n(reset_n),
    .state_alu(state_alu), .state_write(state_write),
    .state_fetch(state_fetch),
    .req_push(req_push), .req_pop(req_pop), .src_m(src_m),
    .ret_pc(ret_pc), .mdata(mdata), .spco(spco),
    .clear_err(clear_err),
    .spcw(spcw), .spcnt(spcnt), .spush(spush),
    .srp(srp), .swp(swp), .spcl(spcl),
    .depth(depth), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic a, w, f, p, q);
    @(negedge clk);
    state_alu = a; state_write = w; state_fetch = f;
    req_push = p; req_pop = q;
    #2;
  endtask

  task automatic do_op(input logic p, q, s, input logic [13:0] pc,
                       input logic [18:0] md);
    src_m = s; ret_pc = pc; mdata = md;
    step(1, 0, 0, p, q);
    step(0, 1, 0, 0, 0);
    o_swp = swp; o_srp = srp; o_cnt = spcnt; o_push = spush; o_w = spcw;
    step(0, 0, 1, 0, 0);
    o_cntf = spcnt;
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    {state_alu, state_write, state_fetch} = 3'b000;
    {req_push, req_pop, src_m, clear_err} = 4'b0000;
    ret_pc = '0; mdata = '0; spco = '0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_depth", depth, 0);
    chk("rst_outs", {spcnt, spush, srp, swp, ovf, unf}, 0);
    chk("rst_spcw", spcw, 0);
    reset_n = 1'b1;

    // reset in the middle of a push
    ret_pc = 14'h0555;
    step(1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    chk("mid_swp", swp, 1);
    reset_n = 1'b0;
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("mid_rst_outs", {spcnt, spush, srp, swp, ovf, unf}, 0);
    chk("mid_rst_regs", {depth, spcw, spcl}, 0);
    reset_n = 1'b1;

    do_op(1, 0, 0, 14'h1234, 19'h0);
    chk("pc_swp", {o_swp, o_srp}, 2'b10);
    chk("pc_cnt", {o_cnt, o_push, o_cntf}, 3'b111);
    chk("pc_spcw", o_w, 19'h01234);
    chk("pc_depth", depth, 1);

    do_op(1, 0, 1, 14'h3FFF, 19'h7ABCD);
    chk("m_spcw", o_w, 19'h7ABCD);
    chk("m_depth", depth, 2);

    spco = 19'h7ABCD;
    do_op(0, 1, 0, 14'h0, 19'h0);
    chk("pop_strobe", {o_swp, o_srp, o_cnt, o_push}, 4'b0110);
    chk("pop_spcl", spcl, 19'h7ABCD);
    chk("pop_depth", depth, 1);

    do_op(1, 1, 0, 14'h0042, 19'h0);
    chk("both_strobe", {o_swp, o_srp}, 2'b10);
    chk("both_depth", depth, 2);

    for (int i = 0; i < 30; i++) do_op(1, 0, 0, 14'(i), 19'h0);
    chk("full_depth", depth, 32);
    chk("full_ovf", ovf, 0);

    do_op(1, 0, 0, 14'h0AAA, 19'h0);
    chk("ovf_depth", depth, 32);
    chk("ovf_flag", ovf, 1);
    chk("ovf_strobe", {o_swp, o_cnt, o_cntf}, GUARD ? 3'b000 : 3'b111);

    clear_err = 1'b1;
    step(0, 0, 0, 0, 0);
    clear_err = 1'b0;
    step(0, 0, 0, 0, 0);
    chk("ovf_clear", ovf, 0);

    // set wins over a simultaneous clear
    clear_err = 1'b1;
    do_op(1, 0, 0, 14'h0BBB, 19'h0);
    clear_err = 1'b0;
    chk("ovf_set_prio", ovf, 1);

    for (int i = 0; i < 32; i++) begin
      spco = 19'(i + 19'h100);
      do_op(0, 1, 0, 14'h0, 19'h0);
    end
    chk("empty_depth", depth, 0);
    chk("empty_spcl", spcl, 19'h11F);
    chk("empty_unf", unf, 0);

    spcl_prev = spcl;
    spco = 19'h11111;
    do_op(0, 1, 0, 14'h0, 19'h0);
    chk("unf_flag", unf, 1);
    chk("unf_depth", depth, 0);
    chk("unf_srp", o_srp, !GUARD);
    chk("unf_spcl", spcl, GUARD ? spcl_prev : 19'h11111);

    clear_err = 1'b1;
    step(0, 0, 0, 0, 0);
    clear_err = 1'b0;
    step(0, 0, 0, 0, 0);
    chk("err_clear", {ovf, unf}, 0);

    // write strobe while idle, and request outside the ALU slot
    step(0, 1, 0, 1, 0);
    chk("idle_write", {swp, srp, spcnt}, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("idle_depth", depth, 0);

    // fetch while armed aborts
    step(1, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("abort_swp", swp, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("abort_depth", depth, 0);

    // back-to-back: next ALU slot coincides with UPDATE
    src_m = 1'b0; ret_pc = 14'h0001;
    step(1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    ret_pc = 14'h0002;
    step(1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    chk("b2b_swp", swp, 1);
    chk("b2b_spcw", spcw, 19'h00002);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("b2b_depth", depth, 2);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
